// File: rtl/aes_pkg.sv
// Shared AES-128 constants and controller state encoding.
// The byte-order constant is shared with the round datapath modules.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int NR_AES128   = 10;

  // byte0 occupies bits [0:7] of a [0:127] vector; bytes are column-major.
  localparam string AES_BYTE_ORDER = "fips197_byte0_bits0to7_column_major";

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: initial AddRoundKey, then NR rounds
// through an external registered datapath, with valid/ready on both sides.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = NR_AES128,
  parameter int ROUND_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:AES_STATE_W-1] plaintext,
  output logic [3:0]             rk_idx,
  input  logic [0:AES_STATE_W-1] rk_data,
  output logic                   dp_start,
  output logic [0:AES_STATE_W-1] dp_state,
  output logic                   dp_final,
  input  logic [0:AES_STATE_W-1] dp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:AES_STATE_W-1] ciphertext,
  output logic                   busy
);

  localparam int               WCNT_W     = $clog2(ROUND_LAT + 1);
  localparam logic [3:0]       LAST_ROUND = 4'(NR);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(ROUND_LAT);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  ctrl_state_e            r_fsm,   w_fsm_nxt;
  logic [0:AES_STATE_W-1] r_state, w_state_nxt;
  logic [3:0]             r_round, w_round_nxt;
  logic [WCNT_W-1:0]      r_wcnt,  w_wcnt_nxt;

  // NOTE: state lives only here and is updated with <=, so every register
  // samples the same pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_wcnt  <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_wcnt_nxt  = r_wcnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dp_start    = 1'b0;
    dp_final    = 1'b0;
    busy        = 1'b1;
    rk_idx      = r_round;
    ciphertext  = '0;

    unique case (r_fsm)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = '0;
        if (in_valid) begin
          w_state_nxt = plaintext ^ rk_data;
          w_round_nxt = 4'd1;
          w_fsm_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dp_start   = 1'b1;
        dp_final   = (r_round == LAST_ROUND);
        w_wcnt_nxt = WCNT_LOAD;
        w_fsm_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        dp_final   = (r_round == LAST_ROUND);
        w_wcnt_nxt = r_wcnt - WCNT_ONE;
        // The datapath result is trusted only in the final wait cycle.
        if (r_wcnt == WCNT_ONE) begin
          w_state_nxt = dp_result;
          if (r_round == LAST_ROUND) begin
            w_fsm_nxt = ST_DONE;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_fsm_nxt   = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        out_valid  = 1'b1;
        ciphertext = r_state;
        if (out_ready) begin
          w_round_nxt = '0;
          w_fsm_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  assign dp_state = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: behavioural AES-128 key store and
// round datapath, reference encryption model, FIPS-197 vectors and random blocks.
module tb_aes_round_ctrl;

  localparam int NR      = 10;
  localparam int LAT     = 4;
  localparam int LATENCY = 1 + NR * (1 + LAT);
  localparam int PERIOD  = LATENCY + 1;
  localparam int BUDGET  = 400;

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] plaintext = '0;
  logic [3:0]   rk_idx;
  logic [0:127] rk_data;
  logic         dp_start;
  logic [0:127] dp_state;
  logic         dp_final;
  logic [0:127] dp_result = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] ciphertext;
  logic         busy;

  logic [0:127] rk_tbl [0:15];
  logic [7:0]   sbox_t [0:255];
  logic [0:127] dp_pend = '0;
  int           dp_dly  = 0;
  int           cyc     = 0;
  int           total   = 0;
  int           bad     = 0;

  aes_round_ctrl #(.NR(NR), .ROUND_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .dp_start  (dp_start),
    .dp_state  (dp_state),
    .dp_final  (dp_final),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk_data = rk_tbl[rk_idx];

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                             input logic fin);
    logic [7:0]   b [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c + r] = b[4*((c + r) % 4) + r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [0:127] aes_enc(input logic [0:127] pt);
    logic [0:127] s;
    s = pt ^ rk_tbl[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rk_tbl[r], r == NR);
    return s;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [0:127] key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= NR) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk_tbl[r] = '0;
    end
  endtask

  // Round datapath model: result valid only in the cycle LAT after dp_start.
  always @(negedge clk) begin
    if (dp_start) begin
      dp_pend   <= aes_round(dp_state, rk_data, dp_final);
      dp_dly    <= LAT;
      dp_result <= rnd128();
    end else if (dp_dly == 1) begin
      dp_dly    <= 0;
      dp_result <= dp_pend;
    end else begin
      if (dp_dly > 0) dp_dly <= dp_dly - 1;
      dp_result <= rnd128();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- one block through both handshakes ----------------
  task automatic run_block(input logic [0:127] pt, input logic [0:127] side_pt,
                           input bit side_valid, input int hold, input bit keep,
                           output logic [0:127] ct, output int acc_c,
                           output int ov_c, output int hs_c);
    int           n, npulse, last, exp_c;
    logic [0:127] held;
    npulse = 0; last = 0; held = '0; ct = '0;
    acc_c = -1; ov_c = -1; hs_c = -1;
    in_valid  = 1'b1;
    plaintext = pt;
    n = 0;
    while (!in_ready && n < BUDGET) begin tick(); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    acc_c = cyc;
    tick();
    in_valid  = side_valid;
    plaintext = side_pt;
    out_ready = side_valid;
    n = 0;
    while (!out_valid && n < BUDGET) begin
      if (dp_start) begin
        npulse++;
        exp_c = (npulse == 1) ? acc_c + 1 : last + 1 + LAT;
        total++;
        if (rk_idx !== 4'(npulse) || cyc != exp_c) begin
          bad++;
          $display("FAIL start_pulse: pulse %0d rk_idx=%0d cycle=%0d, want rk_idx=%0d cycle=%0d",
                   npulse, rk_idx, cyc - acc_c, npulse, exp_c - acc_c);
        end
        last = cyc;
        held = dp_state;
      end else if (npulse > 0) begin
        total++;
        if (rk_idx !== 4'(npulse) || dp_state !== held) begin
          bad++;
          $display("FAIL round_hold: rk_idx=%0d dp_state=%h, want rk_idx=%0d dp_state=%h",
                   rk_idx, dp_state, npulse, held);
        end
      end
      if (npulse > 0) begin
        total++;
        if (dp_final !== (npulse == NR)) begin
          bad++;
          $display("FAIL dp_final: round %0d got %b want %b", npulse, dp_final, npulse == NR);
        end
      end
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_flags: in_ready=%b busy=%b, want 0 1", in_ready, busy);
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, want 1", out_valid, n);
      in_valid = 1'b0;
      return;
    end
    total++;
    if (npulse != NR) begin
      bad++;
      $display("FAIL pulse_count: got %0d want %0d", npulse, NR);
    end
    ov_c = cyc;
    ct   = ciphertext;
    for (int i = 0; i < hold; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || ciphertext !== ct || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure: out_valid=%b in_ready=%b ct=%h, want 1 0 %h",
                 out_valid, in_ready, ciphertext, ct);
      end
    end
    out_ready = 1'b1;
    hs_c = cyc;
    tick();
    out_ready = 1'b0;
    if (!keep) in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    load_key(C1_KEY);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    in_valid  = 1'b1;
    plaintext = C1_PT;
    repeat (8) tick();
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, out_valid, dp_start, dp_final} !== 5'b10000 ||
        rk_idx !== 4'd0 || ciphertext !== '0) begin
      bad++;
      $display("FAIL reset_async: rdy/busy/ov/start/final=%b rk_idx=%0d ct=%h, want 10000 0 0",
               {in_ready, busy, out_valid, dp_start, dp_final}, rk_idx, ciphertext);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({in_ready, busy, out_valid, dp_start, dp_final} !== 5'b10000 ||
          rk_idx !== 4'd0 || ciphertext !== '0) begin
        bad++;
        $display("FAIL reset_idle: cycle %0d rdy/busy/ov/start/final=%b rk_idx=%0d, want 10000 0",
                 i, {in_ready, busy, out_valid, dp_start, dp_final}, rk_idx);
      end
    end
  endtask

  task automatic test_fips();
    logic [0:127] ct;
    int a, o, h;
    load_key(C1_KEY);
    run_block(C1_PT, '0, 1'b0, 0, 1'b0, ct, a, o, h);
    total++;
    if (ct !== C1_CT) begin
      bad++;
      $display("FAIL fips_c1_ct: got %h want %h", ct, C1_CT);
    end
    total++;
    if (o - a != LATENCY) begin
      bad++;
      $display("FAIL fips_c1_latency: got %0d want %0d", o - a, LATENCY);
    end
  endtask

  task automatic test_random();
    logic [0:127] key, pt, ct;
    int a, o, h;
    for (int k = 0; k < 5; k++) begin
      key = (k == 0) ? B_KEY : rnd128();
      pt  = (k == 0) ? B_PT  : rnd128();
      load_key(key);
      run_block(pt, rnd128(), 1'b1, int'($urandom_range(0, 6)), 1'b0, ct, a, o, h);
      total++;
      if (ct !== aes_enc(pt) || (k == 0 && ct !== B_CT)) begin
        bad++;
        $display("FAIL random_ct: block %0d got %h want %h", k, ct, aes_enc(pt));
      end
      total++;
      if (o - a != LATENCY) begin
        bad++;
        $display("FAIL random_latency: block %0d got %0d want %0d", k, o - a, LATENCY);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] pa, pb, cta, ctb;
    int a1, o1, h1, a2, o2, h2;
    load_key(C1_KEY);
    pa = rnd128();
    pb = rnd128();
    run_block(pa, pb, 1'b1, 30, 1'b1, cta, a1, o1, h1);
    run_block(pb, '0, 1'b0, 0, 1'b0, ctb, a2, o2, h2);
    total++;
    if (cta !== aes_enc(pa) || ctb !== aes_enc(pb)) begin
      bad++;
      $display("FAIL bp_ct: got %h %h want %h %h", cta, ctb, aes_enc(pa), aes_enc(pb));
    end
    total++;
    if (h1 - o1 != 30 || a2 != h1 + 1) begin
      bad++;
      $display("FAIL bp_accept: held %0d accept offset %0d, want 30 1", h1 - o1, a2 - h1);
    end
  endtask

  task automatic test_mid_reset();
    logic [0:127] pt, ct;
    int a, o, h, n;
    load_key(rnd128());
    in_valid  = 1'b1;
    plaintext = rnd128();
    n = 0;
    while (!in_ready && n < BUDGET) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!(dp_start && rk_idx == 4'd6) && n < BUDGET) begin tick(); n++; end
    total++;
    if (!(dp_start && rk_idx == 4'd6)) begin
      bad++;
      $display("FAIL mid_reset_reach: rk_idx=%0d dp_start=%b, want 6 1", rk_idx, dp_start);
    end
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, out_valid, dp_start, dp_final} !== 5'b10000 ||
        rk_idx !== 4'd0 || ciphertext !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: rdy/busy/ov/start/final=%b rk_idx=%0d, want 10000 0",
               {in_ready, busy, out_valid, dp_start, dp_final}, rk_idx);
    end
    tick();
    rst = 1'b0;
    tick();
    load_key(rnd128());
    pt = rnd128();
    run_block(pt, rnd128(), 1'b1, 2, 1'b0, ct, a, o, h);
    total++;
    if (ct !== aes_enc(pt) || o - a != LATENCY) begin
      bad++;
      $display("FAIL mid_reset_next: ct=%h lat=%0d, want %h %0d", ct, o - a, aes_enc(pt), LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] pt2;
    logic [0:127] cts [0:1];
    int acc [0:2];
    int ov  [0:1];
    int nacc, nov, n;
    load_key(C1_KEY);
    pt2 = rnd128();
    nacc = 0; nov = 0; n = 0;
    cts[0] = '0; cts[1] = '0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0; ov[0] = 0; ov[1] = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nov < 2 && n < BUDGET) begin
      plaintext = (nacc >= 1) ? pt2 : C1_PT;
      if (in_valid && in_ready && nacc < 3) begin acc[nacc] = cyc; nacc++; end
      if (out_valid) begin ov[nov] = cyc; cts[nov] = ciphertext; nov++; end
      if (nov == 2) in_valid = 1'b0;
      tick();
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (nov != 2 || nacc != 2) begin
      bad++;
      $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2 2", nacc, nov);
    end else begin
      total++;
      if (acc[1] - acc[0] != PERIOD || ov[0] - acc[0] != LATENCY || ov[1] - acc[1] != LATENCY) begin
        bad++;
        $display("FAIL b2b_timing: period=%0d lat0=%0d lat1=%0d, want %0d %0d %0d",
                 acc[1] - acc[0], ov[0] - acc[0], ov[1] - acc[1], PERIOD, LATENCY, LATENCY);
      end
      total++;
      if (cts[0] !== C1_CT || cts[1] !== aes_enc(pt2)) begin
        bad++;
        $display("FAIL b2b_ct: got %h %h want %h %h", cts[0], cts[1], C1_CT, aes_enc(pt2));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
